// File: rtl/byte_word_rx.sv
// ---------------------------------------------------------------------------
// byte_word_rx
//
// Receive-side byte-to-word packer. This is the sink-end companion to the
// registered 8-bit byte stage.
//
// Bytes arrive over a valid/ready/last handshake. They are packed
// little-endian into 32-bit words, each with per-byte keep flags and a
// frame-end marker. Completed words are buffered in a DEPTH-entry FIFO that
// feeds a 32-bit word consumer.
//
// Parameters
//   DEPTH    word FIFO entries (power of 2, >= 2)
//
// Ports
//   clk      clock, all state changes on the rising edge
//   rst_x    asynchronous active-low reset
//   i_valid  byte valid
//   i_data   byte payload
//   i_last   byte is the final byte of a frame
//   o_ready  byte accepted when i_valid && o_ready at the edge (registered)
//   o_valid  FIFO head word valid
//   o_data   head word, byte k in bits [8k+7:8k]
//   o_keep   head word byte-valid mask, bit k covers byte k
//   o_last   head word closes a frame
//   i_ready  word popped when o_valid && i_ready at the edge
//   o_count  words currently held in the FIFO (0..DEPTH)
// ---------------------------------------------------------------------------
module byte_word_rx #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_x,

    input  logic                       i_valid,
    input  logic [7:0]                 i_data,
    input  logic                       i_last,
    output logic                       o_ready,

    output logic                       o_valid,
    output logic [31:0]                o_data,
    output logic [3:0]                 o_keep,
    output logic                       o_last,
    input  logic                       i_ready,

    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    // -----------------------------------------------------------------------
    // Packer state
    // -----------------------------------------------------------------------
    logic [1:0]  lane;
    logic [31:0] acc_data;
    logic [3:0]  acc_keep;

    // -----------------------------------------------------------------------
    // FIFO state
    // -----------------------------------------------------------------------
    logic [31:0]   mem_data [DEPTH];
    logic [3:0]    mem_keep [DEPTH];
    logic          mem_last [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ready_q;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic byte_accept;
    logic word_push;
    logic word_pop;

    assign byte_accept = i_valid && ready_q;

    // A word completes on the fourth lane or on the frame-end byte,
    // whichever comes first.
    assign word_push = byte_accept && ((lane == 2'd3) || i_last);

    // o_valid is derived from count, so a pop can never hit an empty FIFO.
    assign word_pop = o_valid && i_ready;

    // -----------------------------------------------------------------------
    // Word assembly: the accumulator with the incoming byte merged into its
    // lane. Lanes above the current one are still zero from the last clear,
    // which is what zero-fills a partial word.
    // -----------------------------------------------------------------------
    logic [31:0] word_data;
    logic [3:0]  word_keep;

    always_comb begin
        // NOTE: every signal gets a default at the top of the block, so no
        // path leaves it unassigned and no latch is inferred.
        word_data = acc_data;
        word_keep = acc_keep;
        word_data[8*lane +: 8] = i_data;
        word_keep[lane]        = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Next count, used both for the count register and for registered ready.
    // Push is only possible while not full, so the count cannot exceed DEPTH.
    // -----------------------------------------------------------------------
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count;
        case ({word_push, word_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // -----------------------------------------------------------------------
    // Packer registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_x) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values that were present before the edge.
        if (!rst_x) begin
            lane     <= 2'd0;
            acc_data <= 32'd0;
            acc_keep <= 4'd0;
        end else if (byte_accept) begin
            if (word_push) begin
                lane     <= 2'd0;
                acc_data <= 32'd0;
                acc_keep <= 4'd0;
            end else begin
                lane     <= lane + 2'd1;
                acc_data <= word_data;
                acc_keep <= word_keep;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_x) begin
        // NOTE: the storage array is reset too. The head entry drives o_data
        // directly, so clearing it keeps the outputs at zero during and after
        // reset and leaves no stale words visible.
        if (!rst_x) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= 32'd0;
                mem_keep[i] <= 4'd0;
                mem_last[i] <= 1'b0;
            end
        end else if (word_push) begin
            mem_data[wr_ptr] <= word_data;
            mem_keep[wr_ptr] <= word_keep;
            mem_last[wr_ptr] <= i_last;
        end
    end

    // -----------------------------------------------------------------------
    // Pointers, count and registered ready.
    // DEPTH is a power of two, so natural pointer overflow gives the
    // modulo-DEPTH wrap.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (word_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (word_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
            // Ready blocks every byte, including non-completing ones, while
            // the FIFO is full. That way a completing byte never finds the
            // FIFO without room, and the packer needs no stall path.
            ready_q <= (count_next != COUNT_FULL);
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_ready = ready_q;
    assign o_count = count;
    assign o_valid = (count != '0);
    assign o_data  = mem_data[rd_ptr];
    assign o_keep  = mem_keep[rd_ptr];
    assign o_last  = mem_last[rd_ptr];

endmodule

// File: tb/tb_byte_word_rx.sv
// ---------------------------------------------------------------------------
// tb_byte_word_rx
//
// Directed bench for byte_word_rx.
//
// Each byte the DUT accepts updates a reference packer. Every word the
// reference packer completes is pushed onto a scoreboard queue. A monitor
// pops and compares one entry per observed word pop.
//
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// either at that point or on the falling edge.
// ---------------------------------------------------------------------------
module tb_byte_word_rx;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_x;
    logic          i_valid;
    logic [7:0]    i_data;
    logic          i_last;
    logic          o_ready;
    logic          o_valid;
    logic [31:0]   o_data;
    logic [3:0]    o_keep;
    logic          o_last;
    logic          i_ready;
    logic [CW-1:0] o_count;

    byte_word_rx #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_x   (rst_x),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_keep  (o_keep),
        .o_last  (o_last),
        .i_ready (i_ready),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries are {data[31:0], keep[3:0], last}.
    logic [36:0] sb[$];

    // Reference packer.
    int          m_lane = 0;
    logic [31:0] m_data = 32'd0;
    logic [3:0]  m_keep = 4'd0;

    logic rand_done;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] d, input logic l);
        m_data[8*m_lane +: 8] = d;
        m_keep[m_lane]        = 1'b1;
        if (m_lane == 3 || l) begin
            sb.push_back({m_data, m_keep, l});
            m_lane = 0;
            m_data = 32'd0;
            m_keep = 4'd0;
        end else begin
            m_lane++;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_lane = 0;
        m_data = 32'd0;
        m_keep = 4'd0;
    endtask

    // Present one byte and hold it until accepted.
    // Returns 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_last  = l;
        while (!o_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!o_ready) begin
            check("ready_timeout", 64'(o_ready), 64'd1);
        end else begin
            @(posedge clk);
            model_accept(d, l);
            #1;
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        i_ready = 1'b1;
        while (o_count != '0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_count", 64'(o_count), 64'd0);
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: a word pop happens at the next rising edge whenever
    // o_valid && i_ready holds on the falling edge.
    always @(negedge clk) begin
        if (rst_x && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                check("pop_unexpected", 64'd1, 64'd0);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                check("pop_data", 64'(o_data), 64'(e[36:5]));
                check("pop_keep", 64'(o_keep), 64'(e[4:1]));
                check("pop_last", 64'(o_last), 64'(e[0]));
            end
        end
    end

    initial begin
        rst_x   = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'd0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        rand_done = 1'b0;

        // ---- Reset state ----
        idle(2);
        check("rst_ready", 64'(o_ready), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        @(negedge clk);
        rst_x = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_release", 64'(o_ready), 64'd1);

        // ---- Full word 11 22 33 44 with last ----
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        check("w1_valid", 64'(o_valid), 64'd1);
        check("w1_data", 64'(o_data), 64'h44332211);
        check("w1_keep", 64'(o_keep), 64'hF);
        check("w1_last", 64'(o_last), 64'd1);
        idle(1);
        check("w1_valid_one_cycle", 64'(o_valid), 64'd0);
        check("w1_count", 64'(o_count), 64'd0);

        // ---- Partial frame A1 B2 C3, then next frame starts in lane 0 ----
        send_byte(8'hA1, 1'b0);
        send_byte(8'hB2, 1'b0);
        send_byte(8'hC3, 1'b1);
        check("p3_data", 64'(o_data), 64'h00C3B2A1);
        check("p3_keep", 64'(o_keep), 64'h7);
        check("p3_last", 64'(o_last), 64'd1);
        send_byte(8'hD4, 1'b0);
        send_byte(8'hE5, 1'b1);
        check("p2_data", 64'(o_data), 64'h0000E5D4);
        check("p2_keep", 64'(o_keep), 64'h3);
        idle(2);

        // ---- Full backpressure ----
        i_ready = 1'b0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            send_byte(8'(8'h80 + i), 1'b0);
        end
        check("bp_ready_low", 64'(o_ready), 64'd0);
        check("bp_count_full", 64'(o_count), 64'(DEPTH));
        i_valid = 1'b1;
        i_data  = 8'hEE;
        i_last  = 1'b1;
        idle(3);
        check("bp_no_accept_count", 64'(o_count), 64'(DEPTH));
        check("bp_still_not_ready", 64'(o_ready), 64'd0);
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        idle(1);
        i_ready = 1'b0;
        check("bp_one_pop_count", 64'(o_count), 64'(DEPTH - 1));
        check("bp_ready_back", 64'(o_ready), 64'd1);
        drain();

        // ---- Simultaneous push and pop at count 1 ----
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h20 + i), 1'b0);
        i_ready = 1'b1;
        send_byte(8'h23, 1'b0);
        i_ready = 1'b0;
        check("pp1_count", 64'(o_count), 64'd1);

        // ---- Simultaneous push and pop at count DEPTH-1 ----
        for (int i = 0; i < 8; i++) send_byte(8'(8'h30 + i), 1'b0);
        check("pp3_pre_count", 64'(o_count), 64'(DEPTH - 1));
        for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i), 1'b0);
        i_ready = 1'b1;
        send_byte(8'h43, 1'b1);
        i_ready = 1'b0;
        check("pp3_count", 64'(o_count), 64'(DEPTH - 1));
        check("pp3_ready", 64'(o_ready), 64'd1);
        drain();

        // ---- Random gaps across pointer wrap (at least 3*DEPTH words) ----
        fork
            begin
                for (int i = 0; i < 12 * DEPTH; i++) begin
                    send_byte(8'($urandom_range(0, 255)),
                              ($urandom_range(0, 7) == 0));
                    idle($urandom_range(0, 2));
                end
                // Force the last word to close so it is never left partial.
                send_byte(8'hFF, 1'b1);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    i_ready = ($urandom_range(0, 2) != 0) ? 1'b0 : 1'b1;
                end
            end
        join
        drain();

        // ---- Reset mid-word with two words queued ----
        i_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'(8'h60 + i), 1'b0);
        send_byte(8'h70, 1'b0);
        send_byte(8'h71, 1'b0);
        check("mid_pre_count", 64'(o_count), 64'd2);
        rst_x = 1'b0;
        model_reset();
        #2;
        check("mid_rst_ready", 64'(o_ready), 64'd0);
        check("mid_rst_valid", 64'(o_valid), 64'd0);
        check("mid_rst_data", 64'(o_data), 64'd0);
        check("mid_rst_keep", 64'(o_keep), 64'd0);
        check("mid_rst_last", 64'(o_last), 64'd0);
        check("mid_rst_count", 64'(o_count), 64'd0);
        idle(2);
        check("mid_rst_hold_data", 64'(o_data), 64'd0);
        @(negedge clk);
        rst_x = 1'b1;
        @(posedge clk);
        #1;
        check("mid_release_ready", 64'(o_ready), 64'd1);
        i_ready = 1'b1;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        check("mid_word_data", 64'(o_data), 64'h04030201);
        check("mid_word_keep", 64'(o_keep), 64'hF);
        check("mid_word_last", 64'(o_last), 64'd0);
        idle(1);
        check("mid_no_stale", 64'(o_valid), 64'd0);

        // ---- Single-byte frame ----
        send_byte(8'h5A, 1'b1);
        check("one_data", 64'(o_data), 64'h0000005A);
        check("one_keep", 64'(o_keep), 64'h1);
        check("one_last", 64'(o_last), 64'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_word_rx.md
# byte_word_rx

Receive-side counterpart to the team's registered 8-bit byte stage. Accepts a byte stream with a valid/ready/last handshake, packs bytes little-endian into 32-bit words with per-byte keep flags and a frame-end marker, and buffers completed words in a small FIFO. It sits at the sink end of the byte path, feeding a 32-bit word consumer.

## Interface
- DEPTH, 4, word FIFO entries; power of 2, at least 2
- clk  input  1  clock, all logic on rising edge
- rst_x  input  1  reset, asynchronous, active-low
- i_valid  input  1  byte valid
- i_data  input  8  byte payload
- i_last  input  1  byte is the final byte of a frame
- o_ready  output  1  byte accepted when i_valid && o_ready at the edge
- o_valid  output  1  FIFO head word valid
- o_data  output  32  head word; byte k in bits [8k+7:8k]
- o_keep  output  4  head word byte-valid mask; bit k covers byte k
- o_last  output  1  head word closes a frame
- i_ready  input  1  word popped when o_valid && i_ready at the edge
- o_count  output  $clog2(DEPTH)+1  words currently in the FIFO

## Operation
- Byte accept: i_valid && o_ready. Word pop: o_valid && i_ready.
- Packer state:
  - lane counter lane[1:0]
  - 32-bit accumulator
  - 4-bit keep accumulator
- On each byte accept:
  - i_data is written to lane `lane`, and keep bit `lane` is set.
  - If lane==3 or i_last: push {accumulator with the new byte, keep, i_last} to the FIFO in the same edge, then clear lane, accumulator and keep to 0.
  - Otherwise lane increments.
- Partial word (i_last with lane<3):
  - Unused lanes are 0 in o_data.
  - o_keep has only bits 0..lane set: i_last at lane 0 gives 4'b0001, lane 1 gives 4'b0011, lane 2 gives 4'b0111.
- i_last at lane 3: a full word with o_keep=4'b1111 and o_last=1.
- FIFO:
  - DEPTH entries of {data, keep, last}, with write and read pointers that wrap modulo DEPTH.
  - o_count is 0..DEPTH.
  - Push and pop in the same edge leave o_count unchanged, including at o_count==DEPTH-1 and at o_count==1.
  - A pop at o_count==0 cannot occur, because o_valid is low.
- o_ready:
  - Registered; after each edge it equals (count_next != DEPTH).
  - It does not depend combinationally on i_ready.
  - When o_count==DEPTH, o_ready is low and no byte is accepted, even a non-completing byte. This keeps the packer and FIFO simple.
  - A pop at full raises o_ready after that edge.
- o_valid = (o_count != 0). o_data, o_keep and o_last are driven from the FIFO head entry.
- i_data and i_last are ignored when i_valid is low.
- Reset (asynchronous assert, any time including mid-word or mid-frame):
  - lane=0; accumulator and keep cleared; pointers and count=0.
  - All FIFO storage is cleared to 0, and any partial word is discarded.
  - Outputs: o_ready=0, o_valid=0, o_data=0, o_keep=0, o_last=0, o_count=0.
  - On the first edge after rst_x deasserts, o_ready becomes 1.

## Timing
- Byte-to-word latency: the byte that completes a word is accepted at edge N. The word is pushed at edge N, and o_valid/o_data are valid in the cycle after edge N if the FIFO was empty.
- Throughput: one byte per cycle in; one word per cycle out.
- Sustained rate: 4 input bytes per output word, so the FIFO never fills when i_ready is held high.
- o_count and o_ready update on the same edge as the push or pop.
- Full backpressure: with i_ready held low, o_ready falls after the edge that makes o_count==DEPTH. That is the edge accepting the (4·DEPTH)th byte when no frames end early.

## Test plan
- Reset then 4 bytes 0x11,0x22,0x33,0x44 back-to-back, i_last on 0x44, i_ready=1:
  - o_valid high for exactly one cycle after the 4th accept.
  - o_data=0x44332211, o_keep=4'hF, o_last=1, o_count returns to 0.
- Frame 0xA1,0xB2,0xC3 with i_last on 0xC3:
  - o_data=0x00C3B2A1, o_keep=4'b0111, o_last=1.
  - The next frame's first byte lands in lane 0.
- i_ready=0 with continuous bytes, DEPTH=4:
  - o_ready falls after the 16th accept, o_count=4, and no further bytes are taken.
  - Raise i_ready for one cycle: one pop, o_count=3, and o_ready returns high after that edge.
- Simultaneous push and pop at o_count=1 and at o_count=3: o_count unchanged and word order preserved.
  - Also run 3·DEPTH words with random i_valid/i_ready gaps; the scoreboard must match in order across pointer wrap.
- Assert rst_x after 2 bytes of a word and with 2 words queued:
  - All outputs are 0 during reset.
  - After release, bytes 0x01..0x04 produce o_data=0x04030201 with no stale lanes or words.
- Single-byte frame 0x5A with i_last: o_data=0x0000005A, o_keep=4'b0001, o_last=1.
